// File: rtl/lane_checker.sv
// Purpose: receive-side lane endpoint; drains the lane FIFO and checks each word against a stride-X sequence.
// Latency: errcntr/errflg/locked update on the edge that accepts a word and are visible the following cycle.
// Backpressure: rdrdy is en registered by one cycle, independent of rdvld; no word is taken while rdrdy=0.
//
// Ports:
//   clk      checker clock
//   rst      asynchronous active-low reset
//   en       consume enable (rdrdy follows it one cycle late)
//   clr      synchronous clear of errcntr/errflg; wins over a coincident mismatch
//   rddata   FIFO read data, rdvld/rdrdy valid-ready handshake
//   errcntr  saturating mismatch count, errflg sticky mismatch flag
//   locked   high once the first word has been taken since reset

module lane_checker #(
    parameter int W    = 16,
    parameter int EW   = 8,
    parameter int X    = 2,
    parameter bit EDBG = 1'b0,
    parameter     ID   = "LANE"
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [W-1:0]  rddata,
    input  logic          rdvld,
    output logic          rdrdy,
    output logic [EW-1:0] errcntr,
    output logic          errflg,
    output logic          locked
);

    typedef enum logic {
        SYNC  = 1'b0,
        CHECK = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   exp_q, exp_d;
    logic [EW-1:0]  errcntr_q, errcntr_d;
    logic           errflg_q, errflg_d;
    logic           rdrdy_q, rdrdy_d;
    logic           xfer;
    logic           mismatch;

    assign xfer = rdvld & rdrdy_q;

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        errcntr_d = errcntr_q;
        errflg_d  = errflg_q;
        rdrdy_d   = en;
        mismatch  = 1'b0;

        if (xfer) begin
            // On a match rddata equals exp_q, and on a mismatch we resync to
            // rddata, so the next expected word is always rddata + X.
            exp_d = rddata + W'(X);
            if (state_q == SYNC) begin
                state_d = CHECK;
            end else begin
                mismatch = (rddata != exp_q);
            end
        end

        if (mismatch) begin
            errflg_d = 1'b1;
            if (errcntr_q != {EW{1'b1}}) begin
                errcntr_d = errcntr_q + EW'(1);
            end
        end

        if (clr) begin
            errcntr_d = '0;
            errflg_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= SYNC;
            exp_q     <= '0;
            errcntr_q <= '0;
            errflg_q  <= 1'b0;
            rdrdy_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            errcntr_q <= errcntr_d;
            errflg_q  <= errflg_d;
            rdrdy_q   <= rdrdy_d;
        end
    end

    assign rdrdy   = rdrdy_q;
    assign errcntr = errcntr_q;
    assign errflg  = errflg_q;
    assign locked  = (state_q == CHECK);

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (EDBG && rst && mismatch) begin
            $display("[%s] t=%0t lane word mismatch: expected 0x%0h received 0x%0h",
                     ID, $time, exp_q, rddata);
        end
    end
`endif

endmodule

// File: tb/tb_lane_checker.sv
// Purpose: randomized self-checking bench for lane_checker against a stream-level reference model.
// Latency: the model advances on each rising edge; DUT outputs are compared 1ns after the edge.
// Backpressure: the source offers words with random rdvld and only drops a word once it is taken.

module tb_lane_checker;

    localparam int W  = 16;
    localparam int EW = 8;
    localparam int X  = 2;
    localparam int MOD  = 1 << W;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic          en     = 1'b0;
    logic          clr    = 1'b0;
    logic [W-1:0]  rddata = '0;
    logic          rdvld  = 1'b0;
    logic          rdrdy;
    logic [EW-1:0] errcntr;
    logic          errflg;
    logic          locked;

    always #5 clk = ~clk;

    lane_checker #(
        .W(W), .EW(EW), .X(X), .EDBG(1'b0), .ID("TB")
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .rddata(rddata), .rdvld(rdvld), .rdrdy(rdrdy),
        .errcntr(errcntr), .errflg(errflg), .locked(locked)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: stream-level view of the checker.
    bit m_rdy, m_sync, m_flg;
    int m_exp, m_cnt;
    int q[$];
    int vld_pct = 70;

    task automatic model_reset();
        m_rdy = 0; m_sync = 0; m_exp = 0; m_cnt = 0; m_flg = 0;
    endtask

    task automatic cyc();
        bit xf, bad;
        @(posedge clk);
        xf  = rdvld && m_rdy;
        bad = 0;
        if (rst) begin
            if (xf) begin
                if (m_sync && int'(rddata) != m_exp) bad = 1;
                m_sync = 1;
                m_exp  = (int'(rddata) + X) % MOD;
                if (q.size() > 0) void'(q.pop_front());
            end
            if (bad) begin
                if (m_cnt < EMAX) m_cnt++;
                m_flg = 1;
            end
            if (clr) begin
                m_cnt = 0;
                m_flg = 0;
            end
            m_rdy = en;
        end
        #1;
        check_eq("rdrdy",   rdrdy,   m_rdy);
        check_eq("locked",  locked,  m_sync);
        check_eq("errcntr", errcntr, m_cnt);
        check_eq("errflg",  errflg,  m_flg);
    endtask

    task automatic drive();
        rdvld  = (q.size() > 0) && ($urandom_range(99) < vld_pct);
        rddata = (q.size() > 0) ? W'(q[0]) : W'($urandom);
    endtask

    task automatic run_until_empty(input int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            drive();
            cyc();
            n++;
        end
        rdvld = 0;
        check_eq("drain_left", q.size(), 0);
    endtask

    task automatic apply_reset();
        rst = 0;
        q.delete();
        model_reset();
        rdvld = 0;
        repeat (2) cyc();
        rst = 1;
    endtask

    task automatic push_seq(input int start, input int n);
        for (int i = 0; i < n; i++) q.push_back((start + X * i) % MOD);
    endtask

    initial begin
        int k, nxt;
        model_reset();

        // Reset state
        #2;
        check_eq("rst_rdrdy",   rdrdy,   0);
        check_eq("rst_locked",  locked,  0);
        check_eq("rst_errcntr", errcntr, 0);
        check_eq("rst_errflg",  errflg,  0);
        apply_reset();

        // Sync and count
        en = 1;
        push_seq('h0010, 100);
        run_until_empty(1000);
        check_eq("sync_locked",  locked,  1);
        check_eq("sync_errcntr", errcntr, 0);
        check_eq("sync_errflg",  errflg,  0);

        // Single corruption: 0xFF vs 6, then 8 vs 0x101 -> 2 errors
        apply_reset();
        q = '{'h0000, 'h0002, 'h0004, 'h00FF, 'h0008, 'h000A, 'h000C};
        run_until_empty(200);
        check_eq("corr_errcntr", errcntr, 2);
        check_eq("corr_errflg",  errflg,  1);
        push_seq('h000E, 4);
        run_until_empty(200);
        check_eq("corr_noextra", errcntr, 2);

        // Wrap-around and en toggling
        apply_reset();
        q = '{'hFFFC, 'hFFFE, 'h0000, 'h0002};
        run_until_empty(200);
        check_eq("wrap_errcntr", errcntr, 0);
        push_seq('h0004, 60);
        k = 0;
        while (q.size() > 0 && k < 2000) begin
            en = ((k / 3) % 2 == 0);
            drive();
            cyc();
            k++;
        end
        en = 1; rdvld = 0;
        check_eq("toggle_left",    q.size(), 0);
        check_eq("toggle_errcntr", errcntr,  0);

        // Saturation and clear
        apply_reset();
        for (int i = 0; i < 300; i++) q.push_back((i % 2) ? 'h5555 : 'h0000);
        run_until_empty(3000);
        check_eq("sat_errcntr", errcntr, 255);
        check_eq("sat_errflg",  errflg,  1);
        rdvld = 0; clr = 1; cyc(); clr = 0;
        check_eq("clr_errcntr", errcntr, 0);
        check_eq("clr_errflg",  errflg,  0);
        check_eq("clr_locked",  locked,  1);
        q.push_back(m_exp ^ 'h00F0);
        rdvld = 1; rddata = W'(q[0]); clr = 1; cyc(); clr = 0; rdvld = 0;
        check_eq("clrmis_taken",   q.size(), 0);
        check_eq("clrmis_errcntr", errcntr,  0);
        check_eq("clrmis_errflg",  errflg,   0);
        q.push_back(m_exp ^ 'h0001);
        rdvld = 1; rddata = W'(q[0]); cyc(); rdvld = 0;
        check_eq("mis_after_clr", errcntr, 1);

        // Async reset mid-stream
        q = '{'h0100, 'h0300, 'h0500};
        run_until_empty(200);
        check_eq("pre_rst_errflg", errflg, 1);
        #3;
        rst = 0;
        #1;
        check_eq("arst_rdrdy",   rdrdy,   0);
        check_eq("arst_locked",  locked,  0);
        check_eq("arst_errcntr", errcntr, 0);
        check_eq("arst_errflg",  errflg,  0);
        model_reset();
        cyc();
        rst = 1;
        q = '{'h1234, 'h1236};
        run_until_empty(200);
        check_eq("rerun_locked",  locked,  1);
        check_eq("rerun_errcntr", errcntr, 0);

        // Random soak: random en/clr/valid, occasional corrupted words and resets
        apply_reset();
        nxt = $urandom_range(MOD - 1);
        for (int i = 0; i < 3000; i++) begin
            if (q.size() < 4) begin
                q.push_back(($urandom_range(19) == 0) ? int'($urandom_range(MOD - 1)) : nxt);
                nxt = (nxt + X) % MOD;
            end
            en  = ($urandom_range(9) != 0);
            clr = ($urandom_range(49) == 0);
            drive();
            cyc();
            clr = 0;
            if ($urandom_range(999) == 0) apply_reset();
        end
        rdvld = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lane_checker.md
Name: lane_checker

Overview:
- Receive-side endpoint of a lane; counterpart to the lane generator.
- Drains words from the read port of the lane's asynchronous FIFO over a valid/ready handshake.
- Checks each word against an arithmetic sequence of stride X and counts mismatches in a saturating error counter with a sticky flag.
- Instantiated once per lane in the checker clock domain.

Parameters:
- W, 16, data word width in bits.
- EW, 8, error counter width in bits.
- X, 2, expected increment between consecutive words, modulo 2^W.
- EDBG, 0, when 1, print an ID-tagged message on every mismatch (simulation only; no hardware effect).
- ID, "LANE", string tag used in debug messages.

Ports:
- clk, in, 1, checker clock.
- rst, in, 1, reset; asynchronous, active-low.
- en, in, 1, consume enable; when 0, rdy is held low.
- clr, in, 1, synchronous clear of the error counter and flag.
- rddata, in, W, data word from the FIFO read port.
- rdvld, in, 1, rddata is valid.
- rdrdy, out, 1, checker accepts a word this cycle.
- errcntr, out, EW, number of mismatches; saturating.
- errflg, out, 1, sticky; set on the first mismatch.
- locked, out, 1, checker is synchronised to the stream.

Behaviour:
- Reset (rst=0, asynchronous):
  - errcntr=0, errflg=0, locked=0, rdrdy=0.
  - Expected-value register = 0; state = SYNC.
- Handshake:
  - A transfer occurs on a rising clk edge where rdvld=1 and rdrdy=1.
  - rdrdy = en and not in reset; it is registered from en, so it goes low/high one cycle after en does.
  - rdrdy does not depend combinationally on rdvld.
  - No word is consumed when rdvld=0.
- State machine, states SYNC and CHECK:
  - SYNC, on transfer:
    - expected <= rddata + X (mod 2^W).
    - Go to CHECK; locked=1 from the next cycle.
    - No comparison; the error counter is not changed.
  - CHECK, on transfer with rddata == expected:
    - expected <= expected + X (mod 2^W).
    - Stay in CHECK.
  - CHECK, on transfer with rddata != expected:
    - errcntr <= errcntr+1, saturating at 2^EW-1.
    - errflg <= 1.
    - Resynchronise: expected <= rddata + X. Stay in CHECK and keep locked=1, so a single corrupted word produces at most 2 errors.
  - No transfer: all state holds.
- Latency:
  - errcntr and errflg update on the edge that accepts the offending word and are visible in the following cycle.
- clr:
  - errcntr=0 and errflg=0 on the next edge. State, expected and locked are unaffected.
  - If clr coincides with a mismatch, clr wins: counter=0, flag=0.
- Wrap-around:
  - Expected-value arithmetic is modulo 2^W; 0xFFFF+2 expects 0x0001 (W=16, X=2).
- Saturation:
  - At errcntr=2^EW-1, further mismatches leave the counter unchanged and errflg stays 1.
- en deasserted mid-stream:
  - The checker pauses; expected is retained and checking resumes without error when en returns.
- Reset mid-operation:
  - All outputs and state return to their reset values immediately, without waiting for a clock edge.
  - After reset release, the first transfer resynchronises (SYNC).
- EDBG=1 mismatch message: ID, time, expected value, received value.

Test Plan:
- Sync and count: reset; en=1; feed 0x0010, 0x0012, 0x0014 … for 100 words -> locked=1 from cycle after first transfer; errcntr=0; errflg=0.
- Single corruption: stream 0x0000, 0x0002, 0x0004; replace the 4th word 0x0006 with 0x00FF, then continue 0x0008 … -> errcntr=2, errflg=1; no further errors after 0x0008 is followed by 0x000A.
- Wrap and backpressure:
  - Stream 0xFFFC, 0xFFFE, 0x0000, 0x0002 -> errcntr=0.
  - Toggle en every 3 cycles -> rdrdy follows en one cycle late; no words lost; errcntr=0.
- Saturation and clear:
  - Feed 300 words alternating 0x0000/0x5555 with EW=8 -> errcntr=255, errflg=1.
  - Pulse clr -> next cycle errcntr=0, errflg=0; locked stays 1.
  - Pulse clr together with a mismatching word -> errcntr=0, errflg=0.
- Async reset mid-stream:
  - After errors, drive rst=0 between clock edges -> errcntr=0, errflg=0, locked=0, rdrdy=0 before the next edge.
  - Release reset; stream 0x1234, 0x1236 -> locked=1; errcntr=0.
